ula_escalonador: RTL and testbench
==================================

Name: ula_escalonador

Overview:
- Scheduler that shares one 4-bit ALU (AND/OR/ADD/SUB/x2/÷2) between two requesters, channel 0 and channel 1.
- Arbitrates between them, latches the winning operands, and executes the operation in a registered ALU stage.
- Returns the result with a one-cycle acknowledge.
- Drives the last result onto a seven-segment display and counts completed operations; sits between board-level request sources (switch/key logic) and HEX0.

Parameters:
RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, channel 0 always wins.
CNT_W, 8, width of the completed-operation counter.

Ports:
CLOCK_50  input  1  system clock, rising-edge.
RESET_N  input  1  synchronous, active-low reset.
REQ0  input  1  channel 0 request; held high until ACK0.
OP0  input  3  channel 0 opcode.
A0  input  4  channel 0 operand A.
B0  input  4  channel 0 operand B.
REQ1, OP1, A1, B1  input  1/3/4/4  channel 1, same meaning as channel 0.
GNT0  output  1  high while channel 0 owns the ALU (EXEC and DONE).
GNT1  output  1  high while channel 1 owns the ALU (EXEC and DONE).
ACK0  output  1  one-cycle pulse: RESULT/ERR valid for channel 0.
ACK1  output  1  one-cycle pulse: RESULT/ERR valid for channel 1.
RESULT  output  4  result of the last completed operation.
ERR  output  1  last operation used an illegal opcode.
OP_COUNT  output  CNT_W  completed operations, wraps modulo 2^CNT_W.
HEX0  output  7  active-low segments of RESULT; bit6 = a ... bit0 = g.

Behaviour:
- Clock and reset: single clock CLOCK_50; reset is synchronous and active-low (RESET_N sampled on the rising edge).
- Reset values: state IDLE; GNT0/1 = 0; ACK0/1 = 0; RESULT = 0; ERR = 0; OP_COUNT = 0; last-served = channel 1, so channel 0 wins the first tie; HEX0 = 7'b1111111 (blank) until the first completion.
- FSM states: IDLE, EXEC, DONE. Encoding is free.
- IDLE: if no REQ, stay in IDLE. Otherwise select a winner:
  - Only one REQ high: that channel wins.
  - Both high, RR_EN = 1: the channel not last served wins.
  - Both high, RR_EN = 0: channel 0 wins.
  - Latch the winner's OPx/Ax/Bx and channel id; go to EXEC.
- EXEC (1 cycle): GNTx = 1. Compute into the result register, all 4-bit modulo 16:
  - 000: A AND B
  - 001: A OR B
  - 010: A + B (carry dropped)
  - 011: A − B (two's-complement wrap)
  - 100: A << 1 (MSB dropped)
  - 101: A >> 1 (logical)
  - 110/111: result 0, ERR = 1
  - ERR = 0 for all legal opcodes.
  - Go to DONE.
- DONE (1 cycle): GNTx = 1, ACKx = 1; RESULT/ERR stable. OP_COUNT += 1 (illegal opcodes included). Update last-served; go to IDLE.
- Latency: REQ seen in IDLE at edge n; GNT high in cycles n+1 and n+2; ACK high in cycle n+2. Minimum spacing between grants is 3 cycles.
- Operands are captured only in IDLE. Changes to OPx/Ax/Bx or REQx during EXEC/DONE have no effect.
- Requester dropping REQ mid-operation: the operation still completes and ACK still pulses.
- REQ still high in the cycle after ACK: treated as a new request and re-arbitrated. With round-robin, the other channel wins if it is also requesting.
- RESULT/ERR hold their value until the next DONE. Only GNT/ACK are cleared in IDLE.
- HEX0 decode of RESULT, active-low:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - 10–15, or ERR = 1: 1111111 (blank)
  - HEX0 is registered together with RESULT.
- RESET_N low in any state: at the next edge go to IDLE with all reset values. The pending ACK is never issued.

Test Plan:
- Single request: REQ0 = 1, OP0 = 010, A0 = 3, B0 = 4 → GNT0 high 2 cycles, ACK0 pulse 2 cycles after sampling, RESULT = 7, HEX0 = 0001111, OP_COUNT = 1.
- Wrap arithmetic: OP = 011, A = 2, B = 5 → RESULT = 13 (4'hD), HEX0 blank. OP = 010, A = 9, B = 9 → RESULT = 2. OP = 100, A = 9 → RESULT = 2. OP = 101, A = 9 → RESULT = 4.
- Contention, RR_EN = 1: REQ0 and REQ1 held high continuously → grants alternate 0, 1, 0, 1 every 3 cycles; after 4 ACKs, OP_COUNT = 4. With RR_EN = 0, only channel 0 is ever served.
- Illegal opcode: OP1 = 111, A1 = 5 → ACK1 pulse, RESULT = 0, ERR = 1, HEX0 = 1111111, OP_COUNT increments.
- Reset mid-operation: RESET_N = 0 during EXEC → next cycle IDLE, GNT/ACK = 0, RESULT = 0, OP_COUNT = 0, no ACK ever issued; after release, REQ0 wins a tie.
- Operand change and REQ drop: change A0 and drop REQ0 in the EXEC cycle → RESULT reflects the originally latched operands and ACK0 still pulses. With CNT_W = 2, the 4th completion wraps OP_COUNT to 0.

Source files
------------

// File: rtl/ula_escalonador.sv
// ula_escalonador: shares one registered 4-bit ALU between two requesters,
// returns results with a one-cycle ACK and drives RESULT onto a 7-segment digit.
`timescale 1ns/1ps
module ula_escalonador #(
  parameter bit RR_EN = 1'b1,
  parameter int CNT_W = 8
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             REQ0,
  input  logic [2:0]       OP0,
  input  logic [3:0]       A0,
  input  logic [3:0]       B0,
  input  logic             REQ1,
  input  logic [2:0]       OP1,
  input  logic [3:0]       A1,
  input  logic [3:0]       B1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             ACK0,
  output logic             ACK1,
  output logic [3:0]       RESULT,
  output logic             ERR,
  output logic [CNT_W-1:0] OP_COUNT,
  output logic [6:0]       HEX0
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nx;
  logic ch, last, win, alu_err;
  logic [2:0] op;
  logic [3:0] a, b, alu_res;
  logic [6:0] seg;
  always_comb begin
    win = REQ1 & (~REQ0 | (RR_EN & ~last));
    case (state)
      IDLE:    state_nx = (REQ0 | REQ1) ? EXEC : IDLE;
      EXEC:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    alu_err = op[2] & op[1];
    case (op)
      3'd0:    alu_res = a & b;
      3'd1:    alu_res = a | b;
      3'd2:    alu_res = a + b;
      3'd3:    alu_res = a - b;
      3'd4:    alu_res = {a[2:0], 1'b0};
      3'd5:    alu_res = {1'b0, a[3:1]};
      default: alu_res = 4'd0;
    endcase
  end
  // active-low segments a..g; codes above 9 and illegal ops stay blank
  always_comb begin
    case (alu_res)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
    seg = alu_err ? 7'b1111111 : seg;
  end
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state    <= IDLE;
      ch       <= 1'b0;
      last     <= 1'b1;
      op       <= 3'd0;
      a        <= 4'd0;
      b        <= 4'd0;
      RESULT   <= 4'd0;
      ERR      <= 1'b0;
      HEX0     <= 7'b1111111;
      OP_COUNT <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        ch <= win;
        op <= win ? OP1 : OP0;
        a  <= win ? A1 : A0;
        b  <= win ? B1 : B0;
      end
      if (state == EXEC) begin
        RESULT <= alu_res;
        ERR    <= alu_err;
        HEX0   <= seg;
      end
      if (state == DONE) begin
        OP_COUNT <= OP_COUNT + 1'b1;
        last     <= ch;
      end
    end
  end
  assign GNT0 = (state != IDLE) & ~ch;
  assign GNT1 = (state != IDLE) & ch;
  assign ACK0 = (state == DONE) & ~ch;
  assign ACK1 = (state == DONE) & ch;
endmodule

// File: tb/tb_ula_escalonador.sv
// tb_ula_escalonador: directed checks of a round-robin instance (CNT_W=8)
// and a fixed-priority instance (CNT_W=2) driven by the same requesters.
`timescale 1ns/1ps
module tb_ula_escalonador;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [2:0] op0 = 3'd0, op1 = 3'd0;
  logic [3:0] a0 = 4'd0, b0 = 4'd0, a1 = 4'd0, b1 = 4'd0;
  logic rr_gnt0, rr_gnt1, rr_ack0, rr_ack1, rr_err;
  logic [3:0] rr_res;
  logic [7:0] rr_cnt;
  logic [6:0] rr_hex;
  logic fp_gnt0, fp_gnt1, fp_ack0, fp_ack1, fp_err;
  logic [3:0] fp_res;
  logic [1:0] fp_cnt;
  logic [6:0] fp_hex;
  int checks = 0, errors = 0, exp_cnt = 0;

  always #5 clk = ~clk;

  ula_escalonador #(.RR_EN(1'b1), .CNT_W(8)) u_rr (
    .CLOCK_50(clk), .RESET_N(rst_n),
    .REQ0(req0), .OP0(op0), .A0(a0), .B0(b0),
    .REQ1(req1), .OP1(op1), .A1(a1), .B1(b1),
    .GNT0(rr_gnt0), .GNT1(rr_gnt1), .ACK0(rr_ack0), .ACK1(rr_ack1),
    .RESULT(rr_res), .ERR(rr_err), .OP_COUNT(rr_cnt), .HEX0(rr_hex)
  );

  ula_escalonador #(.RR_EN(1'b0), .CNT_W(2)) u_fp (
    .CLOCK_50(clk), .RESET_N(rst_n),
    .REQ0(req0), .OP0(op0), .A0(a0), .B0(b0),
    .REQ1(req1), .OP1(op1), .A1(a1), .B1(b1),
    .GNT0(fp_gnt0), .GNT1(fp_gnt1), .ACK0(fp_ack0), .ACK1(fp_ack1),
    .RESULT(fp_res), .ERR(fp_err), .OP_COUNT(fp_cnt), .HEX0(fp_hex)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one uncontended request on channel c, requester drops REQ when ACK is seen
  task automatic do_op(input logic c, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] er, input logic ee, input logic [6:0] eh);
    if (c) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    else   begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    tick();
    chk("op_gnt", {rr_gnt1, rr_gnt0, rr_ack1, rr_ack0}, c ? 4'b1000 : 4'b0100);
    tick();
    chk("op_ack", {rr_gnt1, rr_gnt0, rr_ack1, rr_ack0}, c ? 4'b1010 : 4'b0101);
    chk("op_res", {rr_err, rr_res, rr_hex}, {ee, er, eh});
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    exp_cnt++;
    chk("op_idle", {rr_gnt1, rr_gnt0, rr_ack1, rr_ack0}, 4'b0000);
    chk("op_cnt", rr_cnt, exp_cnt[7:0]);
    chk("fp_cnt", fp_cnt, exp_cnt[1:0]);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_ctl", {rr_gnt1, rr_gnt0, rr_ack1, rr_ack0, rr_err}, 5'b0);
    chk("rst_res", rr_res, 4'd0);
    chk("rst_cnt", rr_cnt, 8'd0);
    chk("rst_hex", rr_hex, 7'b1111111);
    rst_n = 1'b1;
    tick();
    do_op(1'b0, 3'b010, 4'd3, 4'd4, 4'd7, 1'b0, 7'b0001111);
    do_op(1'b1, 3'b011, 4'd2, 4'd5, 4'hD, 1'b0, 7'b1111111);
    do_op(1'b0, 3'b010, 4'd9, 4'd9, 4'd2, 1'b0, 7'b0010010);
    do_op(1'b0, 3'b100, 4'd9, 4'd0, 4'd2, 1'b0, 7'b0010010);
    chk("fp_wrap", fp_cnt, 2'd0);
    do_op(1'b1, 3'b101, 4'd9, 4'd0, 4'd4, 1'b0, 7'b1001100);
    do_op(1'b1, 3'b111, 4'd5, 4'd0, 4'd0, 1'b1, 7'b1111111);
    chk("err_res_fp", {fp_err, fp_res, fp_hex}, {1'b1, 4'd0, 7'b1111111});
    // operands and REQ change during EXEC must not disturb the latched operation
    req0 = 1'b1; op0 = 3'b000; a0 = 4'hC; b0 = 4'hA;
    tick();
    chk("chg_gnt", rr_gnt0, 1'b1);
    req0 = 1'b0; op0 = 3'b001; a0 = 4'hF;
    tick();
    chk("chg_ack", rr_ack0, 1'b1);
    chk("chg_res", {rr_res, rr_hex}, {4'd8, 7'b0000000});
    tick();
    exp_cnt++;
    chk("chg_idle", {rr_gnt0, rr_ack0}, 2'b00);
    chk("chg_cnt", rr_cnt, exp_cnt[7:0]);
    tick();
    chk("chg_norestart", rr_gnt0, 1'b0);
    // contention: channel 0 served last, so round-robin starts with channel 1
    req0 = 1'b1; op0 = 3'b010; a0 = 4'd1; b0 = 4'd1;
    req1 = 1'b1; op1 = 3'b010; a1 = 4'd3; b1 = 4'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_gnt", {rr_gnt1, rr_gnt0}, (i % 2 == 0) ? 2'b10 : 2'b01);
      chk("fp_gnt", {fp_gnt1, fp_gnt0}, 2'b01);
      tick();
      chk("rr_ack", {rr_ack1, rr_ack0}, (i % 2 == 0) ? 2'b10 : 2'b01);
      chk("rr_res", rr_res, (i % 2 == 0) ? 4'd6 : 4'd2);
      chk("fp_ack", {fp_ack1, fp_ack0, fp_res}, {2'b01, 4'd2});
      if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
      tick();
      exp_cnt++;
      chk("rr_idle", {rr_gnt1, rr_gnt0}, 2'b00);
    end
    chk("rr_cnt4", rr_cnt, exp_cnt[7:0]);
    chk("fp_cnt4", fp_cnt, exp_cnt[1:0]);
    // reset during EXEC aborts the operation without an ACK
    req1 = 1'b1; op1 = 3'b010; a1 = 4'd3; b1 = 4'd3;
    tick();
    chk("rm_gnt", rr_gnt1, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("rm_ctl", {rr_gnt1, rr_gnt0, rr_ack1, rr_ack0, rr_err}, 5'b0);
    chk("rm_res", {rr_res, rr_hex}, {4'd0, 7'b1111111});
    chk("rm_cnt", rr_cnt, 8'd0);
    rst_n = 1'b1;
    req1 = 1'b0;
    tick();
    chk("rm_noack", {rr_gnt1, rr_ack1}, 2'b00);
    req0 = 1'b1; op0 = 3'b001; a0 = 4'd5; b0 = 4'd2;
    req1 = 1'b1;
    tick();
    chk("rm_tie", {rr_gnt1, rr_gnt0}, 2'b01);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    chk("rm_ack", {rr_ack0, rr_res}, {1'b1, 4'd7});
    tick();
    chk("rm_cnt1", rr_cnt, 8'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
